// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, legal-code check and flag bit positions
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

  // Bit positions inside the {Z,N,V} flags vector
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [CTRL_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLT  = 4'b1001,
    OP_SLTU = 4'b1010
  } alu_op_e;

  function automatic logic is_legal_op(input logic [CTRL_W-1:0] code);
    case (code)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU: is_legal_op = 1'b1;
      default:                                 is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way grant selection, round-robin or fixed priority to port 0
module rr_arb2 (
  input  logic [1:0] elig,
  input  logic       rr_en,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie: round-robin favours the port that did not win last time
      2'b11:   grant = (rr_en && !last) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port front end sharing one combinational ALU
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_q,
  output logic [2:0]        rsp0_flags,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_q,
  output logic [2:0]        rsp1_flags,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_q,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v
);

  logic              iss_valid_q, iss_valid_d;
  logic              iss_port_q, iss_port_d;
  logic              iss_err_q, iss_err_d;
  logic [CTRL_W-1:0] iss_ctrl_q, iss_ctrl_d;
  logic [DATA_W-1:0] iss_a_q, iss_a_d;
  logic [DATA_W-1:0] iss_b_q, iss_b_d;
  logic              last_q, last_d;

  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q [2];
  logic [DATA_W-1:0] rsp_data_d [2];
  logic [2:0]        rsp_flags_q [2];
  logic [2:0]        rsp_flags_d [2];
  logic [1:0]        rsp_err_q, rsp_err_d;

  logic [1:0] req_valid, rsp_ready, outstanding, elig, grant, req_ready;
  logic       acc, acc_port;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  rr_arb2 u_arb (
    .elig  (elig),
    .rr_en (RR_EN),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    // A port stays busy until its result has been handed over
    outstanding[0] = (iss_valid_q && !iss_port_q) || (rsp_valid_q[0] && !rsp_ready[0]);
    outstanding[1] = (iss_valid_q &&  iss_port_q) || (rsp_valid_q[1] && !rsp_ready[1]);
    elig      = req_valid & ~outstanding;
    req_ready = reset_n ? (grant & ~outstanding) : 2'b00;
    acc       = |req_ready;
    acc_port  = req_ready[1];

    iss_valid_d = acc;
    iss_port_d  = acc_port;
    iss_ctrl_d  = acc_port ? req1_ctrl : req0_ctrl;
    iss_a_d     = acc_port ? req1_a : req0_a;
    iss_b_d     = acc_port ? req1_b : req0_b;
    iss_err_d   = !is_legal_op(iss_ctrl_d);
    last_d      = acc ? acc_port : last_q;

    for (int n = 0; n < 2; n++) begin
      rsp_valid_d[n] = rsp_valid_q[n] && !rsp_ready[n];
      rsp_data_d[n]  = rsp_data_q[n];
      rsp_flags_d[n] = rsp_flags_q[n];
      rsp_err_d[n]   = rsp_err_q[n];
      if (iss_valid_q && (int'(iss_port_q) == n)) begin
        rsp_valid_d[n]         = 1'b1;
        rsp_err_d[n]           = iss_err_q;
        rsp_data_d[n]          = iss_err_q ? '0 : alu_q;
        rsp_flags_d[n]         = 3'b000;
        rsp_flags_d[n][FLAG_Z] = alu_z && !iss_err_q;
        rsp_flags_d[n][FLAG_N] = alu_n && !iss_err_q;
        rsp_flags_d[n][FLAG_V] = alu_v && !iss_err_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iss_valid_q <= 1'b0;
      iss_port_q  <= 1'b0;
      iss_err_q   <= 1'b0;
      iss_ctrl_q  <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      last_q      <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '{default: '0};
      rsp_flags_q <= '{default: '0};
      rsp_err_q   <= 2'b00;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_port_q  <= iss_port_d;
      iss_err_q   <= iss_err_d;
      iss_ctrl_q  <= iss_ctrl_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // An idle or illegal issue slot presents code 0000 to the shared ALU
  assign alu_a    = iss_valid_q ? iss_a_q : '0;
  assign alu_b    = iss_valid_q ? iss_b_q : '0;
  assign alu_ctrl = (iss_valid_q && !iss_err_q) ? iss_ctrl_q : '0;

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_q     = rsp_data_q[0];
  assign rsp1_q     = rsp_data_q[1];
  assign rsp0_flags = rsp_flags_q[0];
  assign rsp1_flags = rsp_flags_q[1];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_err   = rsp_err_q[1];

endmodule
